// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and long-latency
// writeback, with a per-register busy scoreboard for decode-stage hazard detection.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3
);

    localparam logic GRANT_REQ0 = 1'b0;
    localparam logic GRANT_REQ1 = 1'b1;

    logic                last_grant;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                win_valid;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // Grant: the requester that did not win last time has priority under contention
    always_comb begin
        req0_ready = req0_valid && (!req1_valid || (last_grant == GRANT_REQ1));
        req1_ready = req1_valid && (!req0_valid || (last_grant == GRANT_REQ0));
        win_valid  = req0_ready || req1_ready;
        win_addr   = req0_ready ? req0_addr : req1_addr;
        win_data   = req0_ready ? req0_data : req1_data;
    end

    // Scoreboard update; a same-cycle claim overrides the req1 clear
    always_comb begin
        busy_next = busy;
        if (req1_ready) begin
            busy_next[req1_addr] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_next[claim_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign rs_busy = busy[rs_addr];
    assign rt_busy = busy[rt_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_REQ1;
            busy       <= '0;
            WE3        <= 1'b0;
            A3         <= '0;
            WD3        <= '0;
        end else begin
            busy <= busy_next;
            WE3  <= win_valid && (win_addr != '0);
            if (win_valid) begin
                A3         <= win_addr;
                WD3        <= win_data;
                last_grant <= req0_ready ? GRANT_REQ0 : GRANT_REQ1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued at accept time and
// compared against the write port one cycle later; grants and busy bits follow a reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, claim_valid;
    logic [4:0]  req0_addr, req1_addr, claim_addr, rs_addr, rt_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, rs_busy, rt_busy, WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [37:0] exp_q[$];
    logic        m_last;
    logic [31:0] m_busy;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic        acc0, acc1;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_busy = '0;
        m_a3   = '0;
        m_wd3  = '0;
        exp_q.delete();
    endtask

    // One cycle starting at a negedge with inputs already driven
    task automatic step();
        logic        e0, e1;
        logic [31:0] nb;
        logic [37:0] w;
        #1;
        e0 = req0_valid && (!req1_valid || m_last);
        e1 = req1_valid && (!req0_valid || !m_last);
        check("req0_ready", 64'(req0_ready), 64'(e0));
        check("req1_ready", 64'(req1_ready), 64'(e1));
        check("rs_busy", 64'(rs_busy), 64'(m_busy[rs_addr]));
        check("rt_busy", 64'(rt_busy), 64'(m_busy[rt_addr]));
        if (e0) begin
            exp_q.push_back({(req0_addr != 5'd0), req0_addr, req0_data});
            m_last = 1'b0;
        end else if (e1) begin
            exp_q.push_back({(req1_addr != 5'd0), req1_addr, req1_data});
            m_last = 1'b1;
        end
        nb = m_busy;
        if (e1) nb[req1_addr] = 1'b0;
        if (claim_valid && claim_addr != 5'd0) nb[claim_addr] = 1'b1;
        acc0 = e0;
        acc1 = e1;
        @(posedge clk);
        #1;
        m_busy = nb;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            m_a3  = w[36:32];
            m_wd3 = w[31:0];
            check("WE3", 64'(WE3), 64'(w[37]));
        end else begin
            check("WE3_idle", 64'(WE3), 64'd0);
        end
        check("A3", 64'(A3), 64'(m_a3));
        check("WD3", 64'(WD3), 64'(m_wd3));
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic cv, input logic [4:0] ca,
                         input logic [4:0] rs, input logic [4:0] rt);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        claim_valid = cv; claim_addr = ca;
        rs_addr = rs; rt_addr = rt;
        step();
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs, rt);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        claim_valid = 1'b0; claim_addr = '0; rs_addr = '0; rt_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_WE3", 64'(WE3), 64'd0);
        check("rst_A3", 64'(A3), 64'd0);
        check("rst_WD3", 64'(WD3), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Contention straight out of reset: req0 first, then alternating
        repeat (4) drive(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b0, 5'd0, 5'd1, 5'd2);

        // Single ALU write
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);

        // Scoreboard claim, clear, and claim-wins-over-clear
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        idle(5'd7, 5'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 5'd7, 5'd7);
        idle(5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0778, 1'b1, 5'd7, 5'd7, 5'd7);
        idle(5'd7, 5'd7);
        check("claim_wins", 64'(rs_busy), 64'd1);

        // $zero: accepted but not written, claims ignored
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        drive(1'b1, 5'd0, 32'h0000_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);

        // Back-to-back long-latency writes
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd9, 5'd3, 5'd9);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444_0004, 1'b0, 5'd0, 5'd9, 5'd4);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5555_0005, 1'b0, 5'd0, 5'd9, 5'd5);
        idle(5'd9, 5'd7);

        // Same address from both requesters: both issue in grant order
        repeat (2) drive(1'b1, 5'd6, 32'hA0A0_0006, 1'b1, 5'd6, 32'hB0B0_0006, 1'b0, 5'd0, 5'd6, 5'd6);

        // Randomised traffic; requesters hold until accepted
        idle(5'd0, 5'd0);
        for (int i = 0; i < 80; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = 5'($urandom_range(0, 31));
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = 5'($urandom_range(0, 31));
                req1_data  = $urandom;
            end
            claim_valid = 1'($urandom_range(0, 1));
            claim_addr  = 5'($urandom_range(0, 31));
            rs_addr     = 5'($urandom_range(0, 31));
            rt_addr     = 5'($urandom_range(0, 31));
            step();
        end

        // Mid-cycle reset with a write in flight and busy bits set
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd0, 5'd0);
        drive(1'b1, 5'd12, 32'hC0DE_000C, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 5'd11, 5'd0);
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9999_9999;
        claim_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_WE3", 64'(WE3), 64'd0);
        check("midrst_A3", 64'(A3), 64'd0);
        check("midrst_WD3", 64'(WD3), 64'd0);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            #1;
            check("midrst_rs_busy", 64'(rs_busy), 64'd0);
        end
        model_reset();
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b0;

        // After reset req0 is again favoured under contention
        drive(1'b1, 5'd14, 32'h0E0E_000E, 1'b1, 5'd15, 32'h0F0F_000F, 1'b0, 5'd0, 5'd11, 5'd13);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h0F0F_000F, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
